uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Command-frame controller that sits downstream of the UART receiver. It consumes the one-cycle byte-valid pulses and the received bytes, and sequences them through a 5-byte frame: SYNC, ADDR, DATA_HI, DATA_LO, CHK. It validates each frame by checksum and inter-byte timeout. Each valid frame produces a single register-write strobe to the control register file; each bad frame produces an error pulse and increments an error count.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, 1320, maximum clocks allowed between consecutive bytes inside a frame (about 4 byte times at 33 clocks per bit); legal range 2..65535.

Ports:
i_Clock  in  1  system clock; same clock as the UART receiver.
i_Reset_n  in  1  reset, asynchronous, active-low.
i_Rx_Ready  in  1  byte-valid pulse from the receiver, 1 cycle wide.
i_Rx_Byte  in  8  received byte; valid in any cycle where i_Rx_Ready=1.
o_Wr_Strobe  out  1  1-cycle pulse: a valid frame has been received.
o_Wr_Addr  out  8  register address of the last valid frame.
o_Wr_Data  out  16  {DATA_HI, DATA_LO} of the last valid frame.
o_Frame_Err  out  1  1-cycle pulse: checksum failure or timeout.
o_Err_Count  out  8  count of frame errors; saturates at 8'hFF.
o_Busy  out  1  high while a frame is in progress (state != S_IDLE).

Behaviour:
- Reset (async assert, sync release): state=S_IDLE; all outputs 0; timeout counter 0; internal shadow registers and checksum 0.
- Accepted byte: one with i_Rx_Ready=1 at a rising edge. i_Rx_Byte is ignored when i_Rx_Ready=0.
- States: S_IDLE, S_ADDR, S_DHI, S_DLO, S_CHK.
- S_IDLE:
  - Byte == SYNC_BYTE -> S_ADDR, checksum cleared.
  - Any other byte is dropped silently (no error, no count).
- S_ADDR: capture the byte into the shadow address; sum=byte -> S_DHI.
- S_DHI: capture the byte into shadow data high; sum+=byte -> S_DLO.
- S_DLO: capture the byte into shadow data low; sum+=byte -> S_CHK.
- S_CHK: compare the byte with the sum (8-bit, modulo 256); go to S_IDLE in both cases.
  - Equal: o_Wr_Addr/o_Wr_Data load from the shadows; o_Wr_Strobe=1 for exactly the cycle after the accepting edge.
  - Not equal: o_Frame_Err=1 for 1 cycle; o_Err_Count+1 (saturating); o_Wr_* unchanged.
- SYNC_BYTE inside a frame is ordinary data and does not restart the frame.
- Latency: outputs are registered, so the strobe or error pulse appears 1 clock after the CHK byte edge. o_Wr_Addr/o_Wr_Data change on that same edge and hold until the next valid frame.
- Timeout counter:
  - Clears on every accepted byte and in S_IDLE.
  - Otherwise increments by 1 per clock while state != S_IDLE.
  - When the counter reaches TIMEOUT_CLKS-1 with no byte that cycle: o_Frame_Err pulse, o_Err_Count+1 (saturating), shadows discarded -> S_IDLE.
- Simultaneous byte and timeout in the same cycle: the byte wins (accepted, counter cleared, no error).
- A byte arriving in the cycle right after a timeout is handled as S_IDLE input, so SYNC_BYTE starts a new frame.
- o_Wr_Strobe and o_Frame_Err are never high together; each is high for at most 1 cycle per frame.
- o_Busy is combinational from state: (state != S_IDLE).
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost and no pulse is emitted.
- Back-to-back frames with no idle gap are supported: a SYNC byte arriving the cycle after the CHK byte is accepted.

Test Plan:
- Bytes A5,12,34,56,9C (0x12+0x34+0x56=0x9C), 330 clocks apart -> one o_Wr_Strobe, o_Wr_Addr=12, o_Wr_Data=3456, o_Err_Count=0, o_Busy low after the strobe.
- Bytes A5,12,34,56,9D -> o_Frame_Err 1 cycle, o_Err_Count=1, o_Wr_Addr/o_Wr_Data keep their previous values, no strobe.
- Bytes A5,12 then silence -> o_Frame_Err exactly TIMEOUT_CLKS-1 clocks after the 12 byte; state returns to S_IDLE; a following A5,01,00,02,03 frame -> strobe with addr 01, data 0002.
- Bytes 00,FF,A4 then A5,FF,FF,FF,FD -> no errors for the leading junk; one strobe with addr FF, data FFFF (sum 0x2FD truncated to FD).
- i_Rx_Ready pulse placed exactly on the timeout cycle -> byte accepted and no error; reset_n pulled low after DATA_HI -> all outputs 0, and a fresh full frame then strobes correctly.
- 300 corrupted-checksum frames -> o_Err_Count saturates at FF and stays there.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: assembles 5-byte command frames (SYNC, ADDR, DATA_HI,
// DATA_LO, CHK) from UART receiver byte pulses, validates the checksum and the
// inter-byte timeout, and emits one register-write strobe per good frame or
// an error pulse (with a saturating error count) per bad frame.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1320
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Rx_Ready,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Wr_Strobe,
    output logic [7:0]  o_Wr_Addr,
    output logic [15:0] o_Wr_Data,
    output logic        o_Frame_Err,
    output logic [7:0]  o_Err_Count,
    output logic        o_Busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    // The error fires on the edge where the gap counter would reach
    // TIMEOUT_CLKS-1, i.e. while the registered count still reads TIMEOUT_CLKS-2.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 2);

    state_t      state_reg, state_next;
    logic [15:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0]  addr_sh_reg, addr_sh_next;
    logic [7:0]  dhi_sh_reg, dhi_sh_next;
    logic [7:0]  dlo_sh_reg, dlo_sh_next;
    logic [7:0]  sum_reg, sum_next;
    logic        wr_strobe_reg, wr_strobe_next;
    logic        frame_err_reg, frame_err_next;
    logic [7:0]  wr_addr_reg, wr_addr_next;
    logic [15:0] wr_data_reg, wr_data_next;
    logic [7:0]  err_count_reg, err_count_next;
    logic        timeout_hit;
    logic [7:0]  err_count_inc;

    assign timeout_hit   = (state_reg != S_IDLE) && !i_Rx_Ready && (gap_cnt_reg == TIMEOUT_LAST);
    assign err_count_inc = (err_count_reg == 8'hFF) ? 8'hFF : err_count_reg + 8'd1;

    // State register and all registered outputs/shadows.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_reg     <= S_IDLE;
            gap_cnt_reg   <= '0;
            addr_sh_reg   <= '0;
            dhi_sh_reg    <= '0;
            dlo_sh_reg    <= '0;
            sum_reg       <= '0;
            wr_strobe_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            gap_cnt_reg   <= gap_cnt_next;
            addr_sh_reg   <= addr_sh_next;
            dhi_sh_reg    <= dhi_sh_next;
            dlo_sh_reg    <= dlo_sh_next;
            sum_reg       <= sum_next;
            wr_strobe_reg <= wr_strobe_next;
            frame_err_reg <= frame_err_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            err_count_reg <= err_count_next;
        end
    end

    // Frame sequencing, checksum accumulation and timeout handling.
    always_comb begin
        state_next     = state_reg;
        addr_sh_next   = addr_sh_reg;
        dhi_sh_next    = dhi_sh_reg;
        dlo_sh_next    = dlo_sh_reg;
        sum_next       = sum_reg;
        wr_strobe_next = 1'b0;
        frame_err_next = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        err_count_next = err_count_reg;

        // Gap counter only runs inside a frame and restarts on every byte.
        if (state_reg == S_IDLE || i_Rx_Ready || timeout_hit) begin
            gap_cnt_next = '0;
        end else begin
            gap_cnt_next = gap_cnt_reg + 16'd1;
        end

        if (timeout_hit) begin
            // Stalled frame: report it and throw away the partial contents.
            frame_err_next = 1'b1;
            err_count_next = err_count_inc;
            addr_sh_next   = '0;
            dhi_sh_next    = '0;
            dlo_sh_next    = '0;
            sum_next       = '0;
            state_next     = S_IDLE;
        end else if (i_Rx_Ready) begin
            unique case (state_reg)
                S_IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        sum_next   = '0;
                        state_next = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_sh_next = i_Rx_Byte;
                    sum_next     = i_Rx_Byte;
                    state_next   = S_DHI;
                end
                S_DHI: begin
                    dhi_sh_next = i_Rx_Byte;
                    sum_next    = sum_reg + i_Rx_Byte;
                    state_next  = S_DLO;
                end
                S_DLO: begin
                    dlo_sh_next = i_Rx_Byte;
                    sum_next    = sum_reg + i_Rx_Byte;
                    state_next  = S_CHK;
                end
                S_CHK: begin
                    if (i_Rx_Byte == sum_reg) begin
                        wr_strobe_next = 1'b1;
                        wr_addr_next   = addr_sh_reg;
                        wr_data_next   = {dhi_sh_reg, dlo_sh_reg};
                    end else begin
                        frame_err_next = 1'b1;
                        err_count_next = err_count_inc;
                    end
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign o_Wr_Strobe = wr_strobe_reg;
    assign o_Wr_Addr   = wr_addr_reg;
    assign o_Wr_Data   = wr_data_reg;
    assign o_Frame_Err = frame_err_reg;
    assign o_Err_Count = err_count_reg;
    assign o_Busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed vector table, hand-written corner
// sequences and randomized frames, all checked every clock against a
// frame-level reference model (byte list plus edge-distance timeout).
module tb_uart_rx_frame_ctrl;

    localparam int         T    = 1320;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk;
    logic        rst_n;
    logic        rx_ready;
    logic [7:0]  rx_byte;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    uart_rx_frame_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(T)) dut (
        .i_Clock    (clk),
        .i_Reset_n  (rst_n),
        .i_Rx_Ready (rx_ready),
        .i_Rx_Byte  (rx_byte),
        .o_Wr_Strobe(wr_strobe),
        .o_Wr_Addr  (wr_addr),
        .o_Wr_Data  (wr_data),
        .o_Frame_Err(frame_err),
        .o_Err_Count(err_count),
        .o_Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bytes collected so far in the frame and the edge
    // number of the last accepted byte.
    int          m_edge = 0;
    int          m_n    = 0;
    int          m_last = 0;
    logic [7:0]  m_buf [4];
    logic        m_strobe = 0;
    logic        m_err    = 0;
    logic [7:0]  m_addr   = 0;
    logic [15:0] m_data   = 0;
    logic [7:0]  m_cnt    = 0;

    function automatic logic [34:0] dut_vec();
        return {wr_strobe, frame_err, busy, wr_addr, wr_data, err_count};
    endfunction

    function automatic logic [34:0] model_vec();
        return {m_strobe, m_err, (m_n > 0), m_addr, m_data, m_cnt};
    endfunction

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {stb,err,busy,addr,data,cnt}=%0b,%0b,%0b,%h,%h,%h expected %0b,%0b,%0b,%h,%h,%h",
                     name, act[34], act[33], act[32], act[31:24], act[23:8], act[7:0],
                     exp[34], exp[33], exp[32], exp[31:24], exp[23:8], exp[7:0]);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_strobe = 0; m_err = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit rdy, input logic [7:0] b);
        int s;
        m_edge++;
        m_strobe = 0;
        m_err    = 0;
        if (!rst_n) return;
        if (m_n > 0 && !rdy && (m_edge - m_last) == T - 1) begin
            m_err = 1;
            if (m_cnt != 8'hFF) m_cnt++;
            m_n = 0;
        end else if (rdy) begin
            if (m_n == 0) begin
                if (b == SYNC) begin m_n = 1; m_last = m_edge; end
            end else if (m_n < 4) begin
                m_buf[m_n] = b; m_n++; m_last = m_edge;
            end else begin
                s = (int'(m_buf[1]) + int'(m_buf[2]) + int'(m_buf[3])) % 256;
                if (int'(b) == s) begin
                    m_strobe = 1; m_addr = m_buf[1]; m_data = {m_buf[2], m_buf[3]};
                end else begin
                    m_err = 1;
                    if (m_cnt != 8'hFF) m_cnt++;
                end
                m_n = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, compare just after the edge.
    task automatic step(input bit rdy, input logic [7:0] b);
        rx_ready = rdy;
        rx_byte  = rdy ? b : 8'($urandom);
        @(posedge clk);
        model_edge(rdy, b);
        #1;
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) step(0, 8'h00);
        step(1, b);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo,
                              input logic [7:0] chk, input int gap);
        send(SYNC, gap); send(a, gap); send(hi, gap); send(lo, gap); send(chk, gap);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        rx_ready = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_vec(), 35'd0);
        step(0, 8'h00);
        step(0, 8'h00);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  b;
        int          gap;
        logic        strobe;
        logic        err;
        logic        busy;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int err_at;
        logic [7:0] a, hi, lo, chk;
        int kind, gap, nb;

        vecs[0]  = '{8'hA5, 330, 0, 0, 1, 8'h00, 16'h0000, 8'h00};
        vecs[1]  = '{8'h12, 330, 0, 0, 1, 8'h00, 16'h0000, 8'h00};
        vecs[2]  = '{8'h34, 330, 0, 0, 1, 8'h00, 16'h0000, 8'h00};
        vecs[3]  = '{8'h56, 330, 0, 0, 1, 8'h00, 16'h0000, 8'h00};
        vecs[4]  = '{8'h9C, 330, 1, 0, 0, 8'h12, 16'h3456, 8'h00};
        vecs[5]  = '{8'hA5, 3,   0, 0, 1, 8'h12, 16'h3456, 8'h00};
        vecs[6]  = '{8'h12, 3,   0, 0, 1, 8'h12, 16'h3456, 8'h00};
        vecs[7]  = '{8'h34, 3,   0, 0, 1, 8'h12, 16'h3456, 8'h00};
        vecs[8]  = '{8'h56, 3,   0, 0, 1, 8'h12, 16'h3456, 8'h00};
        vecs[9]  = '{8'h9D, 3,   0, 1, 0, 8'h12, 16'h3456, 8'h01};
        vecs[10] = '{8'h00, 2,   0, 0, 0, 8'h12, 16'h3456, 8'h01};
        vecs[11] = '{8'hFF, 2,   0, 0, 0, 8'h12, 16'h3456, 8'h01};
        vecs[12] = '{8'hA4, 2,   0, 0, 0, 8'h12, 16'h3456, 8'h01};
        vecs[13] = '{8'hA5, 0,   0, 0, 1, 8'h12, 16'h3456, 8'h01};
        vecs[14] = '{8'hFF, 0,   0, 0, 1, 8'h12, 16'h3456, 8'h01};
        vecs[15] = '{8'hFF, 0,   0, 0, 1, 8'h12, 16'h3456, 8'h01};

        rst_n = 1'b0; rx_ready = 1'b0; rx_byte = 8'h00;
        do_reset();

        // Directed vector table: expectation checked right after each byte.
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].b, vecs[i].gap);
            check($sformatf("vec%0d", i), dut_vec(),
                  {vecs[i].strobe, vecs[i].err, vecs[i].busy, vecs[i].addr, vecs[i].data, vecs[i].cnt});
        end
        send(8'hFF, 0);
        send(8'hFD, 0);
        check("sum_trunc", dut_vec(), {1'b1, 1'b0, 1'b0, 8'hFF, 16'hFFFF, 8'h01});
        step(0, 8'h00);
        check("strobe_1cyc", dut_vec(), {1'b0, 1'b0, 1'b0, 8'hFF, 16'hFFFF, 8'h01});

        // Timeout: error exactly T-1 clocks after the last accepted byte.
        send(SYNC, 1);
        send(8'h12, 1);
        err_at = -1;
        for (int k = 1; k <= T + 2; k++) begin
            step(0, 8'h00);
            if (frame_err && err_at < 0) err_at = k;
        end
        n_tests++;
        if (err_at != T - 1) begin
            n_fail++;
            $display("FAIL timeout_clks: got %0d expected %0d", err_at, T - 1);
        end
        check("after_timeout", dut_vec(), {1'b0, 1'b0, 1'b0, 8'hFF, 16'hFFFF, 8'h02});
        send_frame(8'h01, 8'h00, 8'h02, 8'h03, 2);
        check("post_timeout_frame", dut_vec(), {1'b1, 1'b0, 1'b0, 8'h01, 16'h0002, 8'h02});

        // Byte landing exactly on the timeout edge wins.
        send(SYNC, 1);
        send(8'h10, 1);
        repeat (T - 2) step(0, 8'h00);
        step(1, 8'h20);
        check("byte_on_timeout", dut_vec(), {1'b0, 1'b0, 1'b1, 8'h01, 16'h0002, 8'h02});
        send(8'h30, 1);
        send(8'h60, 1);
        check("byte_on_timeout_frame", dut_vec(), {1'b1, 1'b0, 1'b0, 8'h10, 16'h2030, 8'h02});

        // Byte right after a timeout is idle input: SYNC starts a new frame.
        send(SYNC, 0);
        repeat (T - 1) step(0, 8'h00);
        send(SYNC, 0);
        check("sync_after_timeout", dut_vec(), {1'b0, 1'b0, 1'b1, 8'h10, 16'h2030, 8'h03});
        send(8'h07, 0); send(8'h08, 0); send(8'h09, 0); send(8'h18, 0);
        check("sync_after_timeout_frame", dut_vec(), {1'b1, 1'b0, 1'b0, 8'h07, 16'h0809, 8'h03});

        // SYNC value inside a frame is data; back-to-back frames.
        send_frame(8'hA5, 8'hA5, 8'h00, 8'h4A, 0);
        check("sync_as_data", dut_vec(), {1'b1, 1'b0, 1'b0, 8'hA5, 16'hA500, 8'h03});
        send_frame(8'h02, 8'h03, 8'h04, 8'h09, 0);
        check("back_to_back", dut_vec(), {1'b1, 1'b0, 1'b0, 8'h02, 16'h0304, 8'h03});

        // Reset in the middle of a frame.
        send(SYNC, 0); send(8'h11, 0); send(8'h22, 0);
        do_reset();
        check("mid_reset", dut_vec(), 35'd0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h06, 1);
        check("after_reset_frame", dut_vec(), {1'b1, 1'b0, 1'b0, 8'h01, 16'h0203, 8'h00});

        // Randomized frames against the model.
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 5);
            a = 8'($urandom); hi = 8'($urandom); lo = 8'($urandom);
            chk = a + hi + lo;
            gap = $urandom_range(0, 3);
            case (kind)
                0: begin
                    a = 8'($urandom);
                    if (a == SYNC) a = 8'h5A;
                    send(a, gap);
                end
                1, 2: send_frame(a, hi, lo, chk, gap);
                3: send_frame(a, hi, lo, chk ^ 8'($urandom_range(1, 255)), gap);
                4: begin
                    nb = $urandom_range(0, 3);
                    send(SYNC, gap);
                    for (int j = 0; j < nb; j++) send(8'($urandom), gap);
                    repeat (T) step(0, 8'h00);
                end
                default: begin
                    send(SYNC, gap); send(a, gap); send(hi, gap);
                    send(lo, $urandom_range(T - 3, T));
                    send(chk, gap);
                end
            endcase
        end

        // Error counter saturation.
        for (int f = 0; f < 300; f++) send_frame(8'h12, 8'h34, 8'h56, 8'h9D, 0);
        step(0, 8'h00);
        check("err_sat", {32'd0, 3'd0} | {27'd0, err_count}, {27'd0, 8'hFF});
        send_frame(8'h12, 8'h34, 8'h56, 8'h00, 0);
        check("err_sat_hold", {27'd0, err_count}, {27'd0, 8'hFF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
